// File: rtl/logo_glyph_painter_if.sv
// Pixel-side bundle between the VGA timing generator and the glyph painter.
// Latency: none (wires only); the painter registers hit internally.
// Backpressure: none; one pixel is presented and consumed every clock.
interface logo_glyph_painter_if;
    logic        enble;
    logic        run;
    logic        frame_tick;
    logic [1:0]  glyph_sel;
    logic [10:0] x;
    logic [10:0] y;
    logic        hit;
    logic [10:0] delt;

    // Timing generator side: drives pixel position and control, sees result.
    modport master (
        output enble, run, frame_tick, glyph_sel, x, y,
        input  hit, delt
    );

    // Painter side.
    modport slave (
        input  enble, run, frame_tick, glyph_sel, x, y,
        output hit, delt
    );
endinterface

// File: rtl/logo_glyph_painter.sv
// Scaled, horizontally scrolling letter painter (I/L/T/H from up to 3 bars).
// Latency: hit is registered, 1 cycle after x/y/enble; delt is the live register.
// Backpressure: none; accepts one pixel per clock and never stalls.
// Build option: define LOGO_BOUNCE_EN for bounce scrolling, otherwise wrap.
module logo_glyph_painter #(
    parameter int X0       = 500,
    parameter int Y0       = 550,
    parameter int SCALE_SH = 0,
    parameter int SPAN     = 100,
    parameter int STEP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    logo_glyph_painter_if.slave   pix
);

    // One bar of a glyph in unscaled glyph units; v=0 marks an empty slot.
    typedef struct packed {
        logic       v;
        logic [5:0] rx;
        logic [5:0] ry;
        logic [5:0] w;
        logic [5:0] h;
    } bar_t;

    localparam logic [10:0] X0_V   = 11'(X0);
    localparam logic [10:0] Y0_V   = 11'(Y0);
    localparam logic [11:0] SPAN_V = 12'(SPAN);
    localparam logic [11:0] STEP_V = 12'(STEP);

    logic [1:0]  glyph_q;
    logic [10:0] delt_q;
    logic [10:0] delt_nx;
    logic        hit_q;
    logic        hit_nx;

    // Bar table: glyph index and slot number select one rectangle.
    function automatic bar_t bar_lut(input logic [1:0] g, input logic [1:0] s);
        bar_t b;
        b = '0;
        case ({g, s})
            4'b00_00: b = '{1'b1, 6'd10, 6'd0,  6'd20, 6'd5};
            4'b00_01: b = '{1'b1, 6'd20, 6'd0,  6'd5,  6'd40};
            4'b00_10: b = '{1'b1, 6'd10, 6'd40, 6'd20, 6'd5};
            4'b01_00: b = '{1'b1, 6'd10, 6'd0,  6'd5,  6'd45};
            4'b01_01: b = '{1'b1, 6'd10, 6'd40, 6'd20, 6'd5};
            4'b10_00: b = '{1'b1, 6'd5,  6'd0,  6'd25, 6'd5};
            4'b10_01: b = '{1'b1, 6'd15, 6'd0,  6'd5,  6'd45};
            4'b11_00: b = '{1'b1, 6'd5,  6'd0,  6'd5,  6'd45};
            4'b11_01: b = '{1'b1, 6'd25, 6'd0,  6'd5,  6'd45};
            4'b11_10: b = '{1'b1, 6'd5,  6'd20, 6'd25, 6'd5};
            default:  b = '0;
        endcase
        return b;
    endfunction

    // Glyph units to pixels; coordinates stay far below 2047 for legal params.
    function automatic logic [10:0] scl(input logic [5:0] v);
        return 11'({5'b0, v}) << SCALE_SH;
    endfunction

    // Pixel hit test against the latched glyph at the current scroll offset.
    always_comb begin
        bar_t        b;
        logic [10:0] ox;
        logic [10:0] xl, xh, yl, yh;
        logic        any;
        b   = '0;
        xl  = '0;
        xh  = '0;
        yl  = '0;
        yh  = '0;
        any = 1'b0;
        ox  = X0_V + delt_q;
        for (int i = 0; i < 3; i++) begin
            b  = bar_lut(glyph_q, 2'(i));
            xl = ox + scl(b.rx);
            xh = ox + scl(b.rx + b.w);
            yl = Y0_V + scl(b.ry);
            yh = Y0_V + scl(b.ry + b.h);
            if (b.v && (pix.x >= xl) && (pix.x < xh) &&
                (pix.y >= yl) && (pix.y < yh)) begin
                any = 1'b1;
            end
        end
        hit_nx = pix.enble & any;
    end

`ifdef LOGO_BOUNCE_EN
    logic dir_q;   // 0 = forward (increasing), 1 = backward
    logic dir_nx;

    // Bounce: clamp at SPAN and at 0, reversing direction at each end.
    always_comb begin
        logic [11:0] sum;
        sum     = {1'b0, delt_q} + STEP_V;
        delt_nx = delt_q;
        dir_nx  = dir_q;
        if (!dir_q) begin
            if (sum >= SPAN_V) begin
                delt_nx = SPAN_V[10:0];
                dir_nx  = 1'b1;
            end else begin
                delt_nx = sum[10:0];
            end
        end else begin
            if ({1'b0, delt_q} <= STEP_V) begin
                delt_nx = '0;
                dir_nx  = 1'b0;
            end else begin
                delt_nx = delt_q - STEP_V[10:0];
            end
        end
    end

    // Direction only moves together with the offset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dir_q <= 1'b0;
        end else if (pix.frame_tick && pix.run) begin
            dir_q <= dir_nx;
        end
    end
`else
    // Wrap: step forward, restart at 0 once SPAN would be exceeded.
    always_comb begin
        logic [11:0] sum;
        sum     = {1'b0, delt_q} + STEP_V;
        delt_nx = (sum > SPAN_V) ? 11'd0 : sum[10:0];
    end
`endif

    // Frame-rate state plus the registered hit; reset beats a coincident tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            glyph_q <= 2'd0;
            delt_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            hit_q <= hit_nx;
            if (pix.frame_tick) begin
                glyph_q <= pix.glyph_sel;
                if (pix.run) begin
                    delt_q <= delt_nx;
                end
            end
        end
    end

    assign pix.hit  = hit_q;
    assign pix.delt = delt_q;

endmodule

// File: tb/tb_logo_glyph_painter.sv
// Bench for logo_glyph_painter: two instances (unscaled and 2x scaled).
// Latency: expectations for hit lag inputs by one clock.
// Backpressure: not applicable; stimulus is one pixel per clock.
module tb_logo_glyph_painter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        rn  = 1'b0;
    logic        tk  = 1'b0;
    logic [1:0]  gs  = 2'd0;
    logic [10:0] px  = '0;
    logic [10:0] py  = '0;

    always #5 clk = ~clk;

    logo_glyph_painter_if if0();
    logo_glyph_painter_if if1();

    assign if0.enble = en;  assign if1.enble = en;
    assign if0.run = rn;    assign if1.run = rn;
    assign if0.frame_tick = tk; assign if1.frame_tick = tk;
    assign if0.glyph_sel = gs;  assign if1.glyph_sel = gs;
    assign if0.x = px;      assign if1.x = px;
    assign if0.y = py;      assign if1.y = py;

    logo_glyph_painter dut0 (.clk(clk), .rst(rst), .pix(if0));
    logo_glyph_painter #(.X0(500), .Y0(550), .SCALE_SH(1), .SPAN(37), .STEP(5))
        dut1 (.clk(clk), .rst(rst), .pix(if1));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: bar rectangles (rx, ry, w, h); zero width means no bar.
    int bt [4][3][4] = '{
        '{'{10,0,20,5},  '{20,0,5,40},  '{10,40,20,5}},
        '{'{10,0,5,45},  '{10,40,20,5}, '{0,0,0,0}},
        '{'{5,0,25,5},   '{15,0,5,45},  '{0,0,0,0}},
        '{'{5,0,5,45},   '{25,0,5,45},  '{5,20,25,5}}
    };
    int p_sh [2]   = '{0, 1};
    int p_span [2] = '{100, 37};
    int p_step [2] = '{2, 5};

    int m_delt [2];
    int m_dir  [2];
    int m_gly  [2];
    bit e_hit  [2];
    bit started = 1'b0;

    function automatic bit ghit(int g, int d, int sh, int xx, int yy);
        int m;
        m = 1 << sh;
        for (int b = 0; b < 3; b++) begin
            if (xx >= 500 + d + bt[g][b][0] * m &&
                xx <  500 + d + (bt[g][b][0] + bt[g][b][2]) * m &&
                yy >= 550 + bt[g][b][1] * m &&
                yy <  550 + (bt[g][b][1] + bt[g][b][3]) * m)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Model advances on every clock from the inputs present at that edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_delt[k] = 0; m_dir[k] = 0; m_gly[k] = 0; e_hit[k] = 1'b0;
            end else begin
                e_hit[k] = en && ghit(m_gly[k], m_delt[k], p_sh[k], int'(px), int'(py));
                if (tk) begin
                    m_gly[k] = int'(gs);
                    if (rn) begin
`ifdef LOGO_BOUNCE_EN
                        if (m_dir[k] == 0) begin
                            if (m_delt[k] + p_step[k] >= p_span[k]) begin
                                m_delt[k] = p_span[k]; m_dir[k] = 1;
                            end else m_delt[k] = m_delt[k] + p_step[k];
                        end else begin
                            if (m_delt[k] <= p_step[k]) begin
                                m_delt[k] = 0; m_dir[k] = 0;
                            end else m_delt[k] = m_delt[k] - p_step[k];
                        end
`else
                        if (m_delt[k] + p_step[k] > p_span[k]) m_delt[k] = 0;
                        else m_delt[k] = m_delt[k] + p_step[k];
`endif
                    end
                end
            end
        end
        started = 1'b1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            n_cmp += 4;
            if (if0.hit !== e_hit[0]) begin
                n_bad++; $display("FAIL hit0 t=%0t: got %b expected %b", $time, if0.hit, e_hit[0]);
            end
            if (if1.hit !== e_hit[1]) begin
                n_bad++; $display("FAIL hit1 t=%0t: got %b expected %b", $time, if1.hit, e_hit[1]);
            end
            if (if0.delt !== 11'(m_delt[0])) begin
                n_bad++; $display("FAIL delt0 t=%0t: got %0d expected %0d", $time, if0.delt, m_delt[0]);
            end
            if (if1.delt !== 11'(m_delt[1])) begin
                n_bad++; $display("FAIL delt1 t=%0t: got %0d expected %0d", $time, if1.delt, m_delt[1]);
            end
        end
    end

    logic       cur_run = 1'b0;
    logic [1:0] cur_gs  = 2'd0;

    task automatic lit(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int sx, input int sy, input logic se, input logic sr,
                        input logic st, input logic [1:0] sg, input logic srst);
        @(posedge clk);
        #1;
        px = 11'(sx); py = 11'(sy); en = se; rn = sr; tk = st; gs = sg; rst = srst;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b1, cur_run, 1'b1, cur_gs, 1'b1);
        step(0, 0, 1'b1, cur_run, 1'b0, cur_gs, 1'b1);
    endtask

    // Present a pixel, then read hit once that pixel's edge has passed.
    task automatic pt(input int k, input int sx, input int sy, input int exp, input string nm);
        step(sx, sy, 1'b1, cur_run, 1'b0, cur_gs, 1'b1);
        step(sx, sy, 1'b1, cur_run, 1'b0, cur_gs, 1'b1);
        lit(nm, (k == 0) ? int'(if0.hit) : int'(if1.hit), exp);
    endtask

    initial begin
        bit reached;
        step(0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        lit("rst_hit0", int'(if0.hit), 0);
        lit("rst_delt0", int'(if0.delt), 0);
        lit("rst_delt1", int'(if1.delt), 0);

        // Glyph I after reset.
        pt(0, 510, 550, 1, "I_510_550"); pt(0, 509, 550, 0, "I_509_550");
        pt(0, 530, 550, 0, "I_530_550"); pt(0, 520, 560, 1, "I_520_560");
        pt(0, 524, 560, 1, "I_524_560"); pt(0, 525, 560, 0, "I_525_560");
        pt(0, 515, 590, 1, "I_515_590"); pt(0, 515, 595, 0, "I_515_595");

        // Glyph T on the scaled instance.
        cur_run = 1'b0; cur_gs = 2'd2; ticks(1);
        pt(1, 510, 550, 1, "T2_510_550"); pt(1, 509, 550, 0, "T2_509_550");
        pt(1, 530, 639, 1, "T2_530_639"); pt(1, 530, 640, 0, "T2_530_640");

        // Glyph H with run=0, then glyph_sel moves without a tick.
        cur_gs = 2'd3; ticks(1);
        lit("H_delt0", int'(if0.delt), 0);
        pt(0, 505, 560, 1, "H_505_560"); pt(0, 520, 570, 1, "H_520_570");
        pt(0, 520, 560, 0, "H_520_560");
        cur_gs = 2'd0;
        pt(0, 520, 560, 0, "H_midframe");

        // Scrolling.
        cur_run = 1'b1; cur_gs = 2'd0;
        ticks(50);
        lit("scroll_50", int'(if0.delt), 100);
        ticks(1);
`ifdef LOGO_BOUNCE_EN
        lit("scroll_51", int'(if0.delt), 98);
        ticks(49);
        lit("scroll_100", int'(if0.delt), 0);
        ticks(1);
        lit("scroll_101", int'(if0.delt), 2);
        ticks(1);
`else
        lit("scroll_51", int'(if0.delt), 0);
        ticks(2);
`endif
        lit("scroll_at4", int'(if0.delt), 4);
        cur_run = 1'b0;
        pt(0, 514, 550, 1, "I_d4_514"); pt(0, 513, 550, 0, "I_d4_513");

        // Disabled painting.
        step(514, 550, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        step(514, 550, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        lit("enble0", int'(if0.hit), 0);

        // Reset coinciding with a tick at delt=40.
        cur_run = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (m_delt[0] == 40) reached = 1'b1;
            else ticks(1);
        end
        lit("reach_delt40", int'(if0.delt), 40);
        step(510, 550, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0);
        step(510, 550, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
        lit("rsttick_delt", int'(if0.delt), 0);
        lit("rsttick_hit", int'(if0.hit), 0);

        // Random traffic, compared every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            step(480 + int'($urandom_range(219)), 540 + int'($urandom_range(119)),
                 ($urandom_range(7) != 0), ($urandom_range(3) != 0),
                 ($urandom_range(5) == 0), 2'($urandom_range(3)),
                 ($urandom_range(299) != 0));
        end
        step(0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        step(0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logo_glyph_painter.md
# logo_glyph_painter

Animated, parametrised logo-letter painter for the VGA logo path. For the current pixel it reports whether that pixel falls inside a selectable glyph (I, L, T, H), built from up to three axis-aligned bars. The glyph is scaled by a power of two and scrolled horizontally by an internal per-frame offset. It sits between the VGA timing generator (pixel x/y, frame tick) and the colour mux, and replaces the fixed-offset, purely combinational per-letter painters.

## Interface
Parameters:
- X0, 500, glyph cell origin x (pixels, before scroll offset)
- Y0, 550, glyph cell origin y (pixels)
- SCALE_SH, 0, scale shift; all glyph coordinates multiplied by 2^SCALE_SH; legal 0..2
- SPAN, 100, maximum scroll offset (pixels); legal 1..1023
- STEP, 2, offset change per frame tick; legal 1..SPAN

Ports:
- clk, input, 1, pixel clock
- rst, input, 1, synchronous reset, active low
- enble, input, 1, paint enable; 0 forces hit low
- run, input, 1, 1 lets the offset advance on frame ticks
- frame_tick, input, 1, single-cycle pulse at the start of vertical blank
- glyph_sel, input, 2, 0=I, 1=L, 2=T, 3=H; sampled only on frame_tick
- x, input, 11, current pixel column
- y, input, 11, current pixel row
- hit, output, 1, registered: pixel (x,y) lies inside the glyph
- delt, output, 11, current scroll offset

## Operation
- Bars are given in unscaled glyph units as (rx, ry, w, h), relative to the cell origin:
  - I: (10,0,20,5), (20,0,5,40), (10,40,20,5)
  - L: (10,0,5,45), (10,40,20,5)
  - T: (5,0,25,5), (15,0,5,45)
  - H: (5,0,5,45), (25,0,5,45), (5,20,25,5)
- Unused bar slots never hit.
- Each bar's pixel rectangle is half-open:
  - x in [X0+delt+(rx<<SCALE_SH), X0+delt+((rx+w)<<SCALE_SH))
  - y in [Y0+(ry<<SCALE_SH), Y0+((ry+h)<<SCALE_SH))
- All arithmetic is 11-bit unsigned. Parameters must keep every bound at or below 2047; no wrap handling is required.
- hit_next = enble AND (OR of all bar hits for glyph_q).
- glyph_q is the latched glyph select:
  - Loaded from glyph_sel on every frame_tick, regardless of run.
  - Never changes mid-frame.
- Offset update happens on frame_tick when run=1; otherwise delt holds. The update rule depends on the build (see Configuration).
- Reset values: delt=0, glyph_q=0 (I), dir=forward, hit=0.
- When reset and frame_tick occur in the same cycle, reset wins.

## Timing
- hit has 1-cycle latency: the hit asserted in cycle n+1 corresponds to x, y and enble sampled in cycle n.
- The offset and glyph_q change at the clock edge where frame_tick=1. They take effect on hit from the comparison made in the following cycle.
- delt output is the register value, with zero latency.
- Back-to-back frame_tick pulses each step the offset; there is no minimum spacing.
- Reset is fully synchronous. Asserting rst mid-frame sets hit=0 on the next edge and restarts the scroll from 0.

## Configuration
- LOGO_BOUNCE_EN defined: bounce mode using the dir register.
  - Forward: if delt+STEP >= SPAN, then delt=SPAN and dir=backward; else delt += STEP.
  - Backward: if delt <= STEP, then delt=0 and dir=forward; else delt -= STEP.
- LOGO_BOUNCE_EN undefined: wrap mode.
  - If delt+STEP > SPAN, then delt=0; else delt += STEP.
  - The dir register is not built.

## Test plan
- Reset, default parameters, glyph I, delt=0:
  - (510,550) -> hit=1; (509,550) -> 0; (530,550) -> 0.
  - (520,560) -> 1; (524,560) -> 1; (525,560) -> 0.
  - (515,590) -> 1; (515,595) -> 0. Every hit appears one cycle after the input.
- Pulse frame_tick with glyph_sel=3 (H) and run=0:
  - delt stays 0.
  - (505,560) -> 1; (520,570) -> 1; (520,560) -> 0.
  - glyph_sel changed mid-frame without a tick -> painted glyph unchanged.
- run=1, STEP=2, SPAN=100, wrap build:
  - 50 ticks -> delt=100; next tick -> delt=0.
  - With delt=4, glyph I: (514,550) -> hit=1; (513,550) -> 0.
- Bounce build:
  - 50 ticks -> delt=100; next tick -> 98.
  - 49 further ticks -> 0; next tick -> 2.
- SCALE_SH=1, glyph T:
  - (510,550) -> 1; (509,550) -> 0; (530,639) -> 1; (530,640) -> 0.
- enble=0 -> hit=0 everywhere.
- rst low together with frame_tick, with delt=40 -> delt=0, hit=0 next edge.
